io_port_loader: RTL
===================

IO_PORT_LOADER -- requirements
Module: io_port_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 32: memory word width; SHALL be a multiple of BEAT_W.
REQ-002 SHALL have parameter BEAT_W, default 8: pin-bus beat width.
REQ-003 SHALL have parameter NUM_CH, default 2: number of memory channels (ch0 = instruction, ch1 = data).
REQ-004 SHALL have parameter ADDR_W, default 10: word address width.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 host_valid  in  1  host beat/command valid.
REQ-008 host_ready  out  1  block accepts beat.
REQ-009 host_cmd  in  2  00 DATA, 01 SET_CH, 10 SET_ADDR, 11 READ.
REQ-010 host_data  in  BEAT_W  beat payload.
REQ-011 rd_valid / rd_ready / rd_data  out / in / out  1 / 1 / BEAT_W  readback beat stream.
REQ-012 mem_we, mem_re  out  NUM_CH  one-hot per-channel strobes.
REQ-013 mem_addr / mem_wdata  out  ADDR_W / WIDTH  shared memory address and write data.
REQ-014 mem_rdata  in  NUM_CH*WIDTH  channel c at [c*WIDTH +: WIDTH]; synchronous memory, 1-cycle read latency.
REQ-015 busy / err  out  1 / 1  state != IDLE / sticky error.

Function
REQ-016 Transfer SHALL occur on a cycle with host_valid && host_ready; rd beat on rd_valid && rd_ready.
REQ-017 FSM states SHALL be IDLE, WRITE, READ, CAPTURE, SEND; host_ready SHALL be 1 only in IDLE.
REQ-018 DATA: beat shifted into packer, LSB beat first; on beat WIDTH/BEAT_W the FSM SHALL enter WRITE.
REQ-019 WRITE (one cycle): mem_we[ch]=1, mem_addr=addr, mem_wdata=packed word; then addr+1, beat count 0, IDLE.
REQ-020 SET_CH: ch <= host_data; value >= NUM_CH SHALL set err and leave ch unchanged.
REQ-021 SET_ADDR: addr <= {addr, host_data} truncated to ADDR_W (shift-in, so wide addresses take several beats).
REQ-022 SET_CH, SET_ADDR or READ with a partial word pending SHALL discard the partial beats; no write.
REQ-023 READ: mem_re[ch]=1 one cycle (READ); CAPTURE latches slice ch of mem_rdata; SEND emits WIDTH/BEAT_W beats LSB first.
REQ-024 In SEND, rd_data SHALL hold stable while rd_valid && !rd_ready; after last beat accepted, addr+1, IDLE.
REQ-025 Address increment SHALL wrap 2^ADDR_W-1 -> 0 silently.
REQ-026 mem_we, mem_re SHALL be zero outside WRITE / READ; never more than one bit set.

Reset
REQ-027 reset SHALL immediately force IDLE, ch=0, addr=0, beat count 0, packer 0, err=0.
REQ-028 During reset: host_ready=0, rd_valid=0, rd_data=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, busy=0.
REQ-029 Reset mid-operation SHALL abort it; the in-flight word SHALL be lost with no write strobe.

Configuration
REQ-030 Macro IO_READBACK_EN defined: READ, CAPTURE, SEND and rd_* path present per REQ-023/024.
REQ-031 Macro undefined: READ cmd SHALL set err and be consumed; mem_re, rd_valid, rd_data tied 0; mem_rdata unused.

Structure
REQ-032 Package io_pkg SHALL hold the state enum typedef and the host_cmd encodings.
REQ-033 Sub-module io_word_packer SHALL implement beat shift-in/shift-out and beat counter; FSM and address counter stay in io_port_loader.

Verification (WIDTH=32, BEAT_W=8, NUM_CH=2, ADDR_W=4)
REQ-034 SET_CH 0, SET_ADDR 0x03, DATA 0x78,0x56,0x34,0x12 -> one cycle mem_we=2'b01, mem_addr=3, mem_wdata=0x12345678; next write at addr 4.
REQ-035 SET_ADDR 0x0F, four DATA beats twice -> writes at addr 15 then 0.
REQ-036 SET_CH 1, SET_ADDR 0x02, READ, ch1 rdata 0xCAFEBABE, rd_ready low 3 cycles -> mem_re=2'b10 once; rd_data 0xBE,0xBA,0xFE,0xCA, stable while stalled.
REQ-037 SET_CH 0x05 -> err=1, ch stays 0; err persists until reset; without IO_READBACK_EN, READ -> err=1, no mem_re.
REQ-038 DATA 0xAA,0xBB then SET_ADDR 0x01 then DATA 0x01,0x02,0x03,0x04 -> single write, addr 1, wdata 0x04030201.
REQ-039 reset asserted during SEND -> rd_valid=0, busy=0 same cycle; post-reset READ uses ch 0, addr 0.

Source files
------------

// File: rtl/io_pkg.sv
// Shared FSM state type and host command encodings for the IO port loader.
package io_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_READ    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_SEND    = 3'd4
    } state_e;

    localparam logic [1:0] CMD_DATA     = 2'b00;
    localparam logic [1:0] CMD_SET_CH   = 2'b01;
    localparam logic [1:0] CMD_SET_ADDR = 2'b10;
    localparam logic [1:0] CMD_READ     = 2'b11;

endpackage

// File: rtl/io_word_packer.sv
// Beat <-> word packer: shifts beats in LSB-first, loads a word and shifts it out
// LSB-first, and counts beats in either direction.
module io_word_packer
    import io_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int BEAT_W = 8,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic              shift_in_i,
    input  logic              shift_out_i,
    input  logic [BEAT_W-1:0] beat_i,
    input  logic [WIDTH-1:0]  word_i,
    output logic [WIDTH-1:0]  word_o,
    output logic [BEAT_W-1:0] beat_o,
    output logic [CNT_W-1:0]  cnt_o
);

    logic [WIDTH-1:0] word_q, word_d;
    logic [WIDTH-1:0] shifted_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next word/count: clear beats load, load beats shifting.
    always_comb begin
        word_d    = word_q;
        cnt_d     = cnt_q;
        shifted_s = word_q >> BEAT_W;
        if (clr_i) begin
            word_d = {WIDTH{1'b0}};
            cnt_d  = {CNT_W{1'b0}};
        end else if (load_i) begin
            word_d = word_i;
            cnt_d  = {CNT_W{1'b0}};
        end else if (shift_in_i) begin
            shifted_s[WIDTH-1 -: BEAT_W] = beat_i;
            word_d = shifted_s;
            cnt_d  = cnt_q + CNT_W'(1'b1);
        end else if (shift_out_i) begin
            word_d = shifted_s;
            cnt_d  = cnt_q + CNT_W'(1'b1);
        end else begin
            word_d = word_q;
            cnt_d  = cnt_q;
        end
    end

    // Word and beat-count registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= {WIDTH{1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_o = word_q;
    assign beat_o = word_q[BEAT_W-1:0];
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/io_port_loader.sv
// Host pin-bus loader for multi-channel memories. Optional readback path is
// enabled by defining IO_READBACK_EN; without it READ is consumed and flags err.
module io_port_loader
    import io_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int BEAT_W = 8,
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     host_valid,
    output logic                     host_ready,
    input  logic [1:0]               host_cmd,
    input  logic [BEAT_W-1:0]        host_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [BEAT_W-1:0]        rd_data,
    output logic [NUM_CH-1:0]        mem_we,
    output logic [NUM_CH-1:0]        mem_re,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [WIDTH-1:0]         mem_wdata,
    input  logic [NUM_CH*WIDTH-1:0]  mem_rdata,
    output logic                     busy,
    output logic                     err
);

    localparam int NBEATS = WIDTH / BEAT_W;
    localparam int CNT_W  = $clog2(NBEATS + 1);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    state_e              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                err_q, err_d;
    logic                ready_q;

    logic                pk_clr_s, pk_load_s, pk_in_s, pk_out_s;
    logic [WIDTH-1:0]    pk_word_s;
    logic [BEAT_W-1:0]   pk_beat_s;
    logic [CNT_W-1:0]    pk_cnt_s;
    logic [WIDTH-1:0]    rdata_sel_s;
    logic                host_fire_s;
    logic [ADDR_W+BEAT_W-1:0] addr_shift_s;
    logic [NUM_CH-1:0]   ch_onehot_s;

    assign host_fire_s  = host_valid && ready_q;
    assign addr_shift_s = {addr_q, host_data};
    assign ch_onehot_s  = NUM_CH'(1'b1) << ch_q;

    io_word_packer #(
        .WIDTH  (WIDTH),
        .BEAT_W (BEAT_W),
        .CNT_W  (CNT_W)
    ) u_packer (
        .clk         (clk),
        .reset       (reset),
        .clr_i       (pk_clr_s),
        .load_i      (pk_load_s),
        .shift_in_i  (pk_in_s),
        .shift_out_i (pk_out_s),
        .beat_i      (host_data),
        .word_i      (rdata_sel_s),
        .word_o      (pk_word_s),
        .beat_o      (pk_beat_s),
        .cnt_o       (pk_cnt_s)
    );

    // Next-state, channel/address/error updates and packer control.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        addr_d    = addr_q;
        err_d     = err_q;
        pk_clr_s  = 1'b0;
        pk_load_s = 1'b0;
        pk_in_s   = 1'b0;
        pk_out_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (host_fire_s) begin
                    case (host_cmd)
                        CMD_DATA: begin
                            pk_in_s = 1'b1;
                            if (pk_cnt_s == LAST_BEAT) begin
                                state_d = ST_WRITE;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                        CMD_SET_CH: begin
                            pk_clr_s = 1'b1;
                            if (host_data < BEAT_W'(NUM_CH)) begin
                                ch_d = CH_W'(host_data);
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        CMD_SET_ADDR: begin
                            // Shift-in so addresses wider than a beat take several commands.
                            pk_clr_s = 1'b1;
                            addr_d   = addr_shift_s[ADDR_W-1:0];
                        end
                        CMD_READ: begin
                            pk_clr_s = 1'b1;
`ifdef IO_READBACK_EN
                            state_d = ST_READ;
`else
                            err_d = 1'b1;
`endif
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                pk_clr_s = 1'b1;
                addr_d   = addr_q + ADDR_W'(1'b1);
                state_d  = ST_IDLE;
            end
            ST_READ: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                pk_load_s = 1'b1;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (rd_ready) begin
                    pk_out_s = 1'b1;
                    if (pk_cnt_s == LAST_BEAT) begin
                        pk_clr_s = 1'b1;
                        addr_d   = addr_q + ADDR_W'(1'b1);
                        state_d  = ST_IDLE;
                    end else begin
                        state_d = ST_SEND;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers; ready is registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ch_q    <= {CH_W{1'b0}};
            addr_q  <= {ADDR_W{1'b0}};
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            ready_q <= (state_d == ST_IDLE);
        end
    end

    assign host_ready = ready_q;
    assign busy       = (state_q != ST_IDLE);
    assign err        = err_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = pk_word_s;
    assign mem_we     = (state_q == ST_WRITE) ? ch_onehot_s : {NUM_CH{1'b0}};

`ifdef IO_READBACK_EN
    assign rdata_sel_s = mem_rdata[ch_q*WIDTH +: WIDTH];
    assign mem_re      = (state_q == ST_READ) ? ch_onehot_s : {NUM_CH{1'b0}};
    assign rd_valid    = (state_q == ST_SEND);
    assign rd_data     = (state_q == ST_SEND) ? pk_beat_s : {BEAT_W{1'b0}};
`else
    logic unused_readback_s;
    assign unused_readback_s = ^{mem_rdata, pk_beat_s};
    assign rdata_sel_s = {WIDTH{1'b0}};
    assign mem_re      = {NUM_CH{1'b0}};
    assign rd_valid    = 1'b0;
    assign rd_data     = {BEAT_W{1'b0}};
`endif

endmodule
